// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction engine: FSM state encoding,
// default credit ceiling and the slot-index width helper.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    localparam int unsigned CREDIT_MAX_DEF = 995;

    // Width of a slot index; at least one bit.
    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_inventory_bank.sv
// Per-slot inventory counters. Restock overrides a same-cycle decrement of the
// same slot; a restock index outside the slot range matches no counter.
// Ports: clk/rst_n, restock_{valid,slot,count}_i, dec_{valid,slot}_i, inv_flat_o.
module vend_inventory_bank
    import vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned CNT_W     = 5,
    localparam int unsigned SW       = slot_w(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restock_valid_i,
    input  logic [SW-1:0]              restock_slot_i,
    input  logic [CNT_W-1:0]           restock_count_i,
    input  logic                       dec_valid_i,
    input  logic [SW-1:0]              dec_slot_i,
    output logic [NUM_SLOTS*CNT_W-1:0] inv_flat_o
);

    logic [CNT_W-1:0] cnt_q [NUM_SLOTS];

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
            end else if (restock_valid_i && (restock_slot_i == SW'(i))) begin
                cnt_q[i] <= restock_count_i;
            end else if (dec_valid_i && (dec_slot_i == SW'(i)) && (cnt_q[i] != '0)) begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end

        assign inv_flat_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: rtl/vend_txn_engine.sv
// Vending transaction engine: credit accumulation, selection check, vend,
// and change hand-off to a ready/valid dispenser. Excess coins and coins that
// arrive while busy go to a backlog returned with the next vend or refund.
// Ports: coin/sel/refund/restock requests and price table in; credit, vend,
// change handshake, error pulses, inventory counts and busy out.
module vend_txn_engine
    import vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MONEY_W    = 10,
    parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
    localparam int unsigned SW        = slot_w(NUM_SLOTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [7:0]                   coin_value,
    input  logic                         sel_valid,
    input  logic [SW-1:0]                sel_slot,
    input  logic                         refund_req,
    input  logic [NUM_SLOTS*MONEY_W-1:0] price_flat,
    input  logic                         restock_valid,
    input  logic [SW-1:0]                restock_slot,
    input  logic [CNT_W-1:0]             restock_count,
    input  logic                         change_ready,
    output logic [MONEY_W-1:0]           credit,
    output logic                         vend_valid,
    output logic [SW-1:0]                vend_slot,
    output logic                         change_valid,
    output logic [MONEY_W-1:0]           change_amt,
    output logic                         err_sold_out,
    output logic                         err_funds,
    output logic                         err_invalid,
    output logic [NUM_SLOTS*CNT_W-1:0]   inv_flat,
    output logic                         busy
);

    localparam int unsigned MW1 = MONEY_W + 1;
    localparam logic [MONEY_W-1:0] CMAX = MONEY_W'(CREDIT_MAX);

    vend_state_e        state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] backlog_q, backlog_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [SW-1:0]      vend_slot_q, vend_slot_d;
    logic               vend_valid_q, vend_valid_d;
    logic               err_sold_out_q, err_sold_out_d;
    logic               err_funds_q, err_funds_d;
    logic               err_invalid_q, err_invalid_d;
    logic               change_valid_q, busy_q;

    logic               dec_valid_c;
    logic               coin_to_bl;
    logic               slot_ok;
    logic [SW-1:0]      sel_idx;
    logic [MONEY_W-1:0] price_sel;
    logic [CNT_W-1:0]   cnt_sel;
    logic [MONEY_W-1:0] diff;
    logic [MONEY_W:0]   csum, rsum, vsum;

    logic [MONEY_W-1:0] price_arr [NUM_SLOTS];
    logic [CNT_W-1:0]   cnt_arr   [NUM_SLOTS];

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_unpack
        assign price_arr[i] = price_flat[i*MONEY_W +: MONEY_W];
        assign cnt_arr[i]   = inv_flat[i*CNT_W +: CNT_W];
    end

    // Clamp a MONEY_W+1 result to the MONEY_W range.
    function automatic logic [MONEY_W-1:0] sat_w(input logic [MONEY_W:0] v);
        return v[MONEY_W] ? '1 : v[MONEY_W-1:0];
    endfunction

    function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                   input logic [MONEY_W-1:0] b);
        return sat_w({1'b0, a} + {1'b0, b});
    endfunction

    // Latched slot lookup; out-of-range indices are redirected to slot 0.
    assign slot_ok   = (32'(sel_q) < NUM_SLOTS);
    assign sel_idx   = slot_ok ? sel_q : '0;
    assign price_sel = price_arr[sel_idx];
    assign cnt_sel   = cnt_arr[sel_idx];

    vend_inventory_bank #(
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W)
    ) u_inv (
        .clk             (clk),
        .rst_n           (reset),
        .restock_valid_i (restock_valid),
        .restock_slot_i  (restock_slot),
        .restock_count_i (restock_count),
        .dec_valid_i     (dec_valid_c),
        .dec_slot_i      (sel_q),
        .inv_flat_o      (inv_flat)
    );

    // Next-state and transaction datapath.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        backlog_d      = backlog_q;
        change_d       = change_q;
        sel_d          = sel_q;
        vend_slot_d    = vend_slot_q;
        vend_valid_d   = 1'b0;
        err_sold_out_d = 1'b0;
        err_funds_d    = 1'b0;
        err_invalid_d  = 1'b0;
        dec_valid_c    = 1'b0;
        coin_to_bl     = coin_valid;

        csum = {1'b0, credit_q} + MW1'(coin_value);
        rsum = {1'b0, credit_q} + {1'b0, backlog_q};
        diff = (credit_q >= price_sel) ? (credit_q - price_sel) : '0;
        vsum = {1'b0, diff} + {1'b0, backlog_q};

        unique case (state_q)
            ST_IDLE: begin
                if (refund_req) begin
                    change_d  = sat_w(rsum);
                    credit_d  = '0;
                    backlog_d = '0;
                    if (rsum != '0) state_d = ST_CHANGE;
                end else if (sel_valid) begin
                    sel_d   = sel_slot;
                    state_d = ST_CHECK;
                end else if (coin_valid) begin
                    coin_to_bl = 1'b0;
                    if (csum > {1'b0, CMAX}) begin
                        credit_d  = CMAX;
                        backlog_d = sat_add(backlog_q, MONEY_W'(csum - {1'b0, CMAX}));
                    end else begin
                        credit_d = csum[MONEY_W-1:0];
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!slot_ok) begin
                    err_invalid_d = 1'b1;
                end else if (cnt_sel == '0) begin
                    err_sold_out_d = 1'b1;
                end else if (credit_q < price_sel) begin
                    err_funds_d = 1'b1;
                end else begin
                    vend_valid_d = 1'b1;
                    vend_slot_d  = sel_q;
                    state_d      = ST_VEND;
                end
            end
            ST_VEND: begin
                dec_valid_c = 1'b1;
                change_d    = sat_w(vsum);
                credit_d    = '0;
                backlog_d   = '0;
                state_d     = (vsum == '0) ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE: begin
                if (change_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Coins not absorbed into credit are never dropped.
        if (coin_to_bl) backlog_d = sat_add(backlog_d, MONEY_W'(coin_value));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            backlog_q      <= '0;
            change_q       <= '0;
            sel_q          <= '0;
            vend_slot_q    <= '0;
            vend_valid_q   <= 1'b0;
            err_sold_out_q <= 1'b0;
            err_funds_q    <= 1'b0;
            err_invalid_q  <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            backlog_q      <= backlog_d;
            change_q       <= change_d;
            sel_q          <= sel_d;
            vend_slot_q    <= vend_slot_d;
            vend_valid_q   <= vend_valid_d;
            err_sold_out_q <= err_sold_out_d;
            err_funds_q    <= err_funds_d;
            err_invalid_q  <= err_invalid_d;
            change_valid_q <= (state_d == ST_CHANGE);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign credit       = credit_q;
    assign vend_valid   = vend_valid_q;
    assign vend_slot    = vend_slot_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_q;
    assign err_sold_out = err_sold_out_q;
    assign err_funds    = err_funds_q;
    assign err_invalid  = err_invalid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_txn_engine.sv
// Directed bench for vend_txn_engine with hand-computed expectations.
module tb_vend_txn_engine;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned MONEY_W   = 10;
    localparam int unsigned SW        = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         coin_valid;
    logic [7:0]                   coin_value;
    logic                         sel_valid;
    logic [SW-1:0]                sel_slot;
    logic                         refund_req;
    logic [NUM_SLOTS*MONEY_W-1:0] price_flat;
    logic                         restock_valid;
    logic [SW-1:0]                restock_slot;
    logic [CNT_W-1:0]             restock_count;
    logic                         change_ready;
    logic [MONEY_W-1:0]           credit;
    logic                         vend_valid;
    logic [SW-1:0]                vend_slot;
    logic                         change_valid;
    logic [MONEY_W-1:0]           change_amt;
    logic                         err_sold_out;
    logic                         err_funds;
    logic                         err_invalid;
    logic [NUM_SLOTS*CNT_W-1:0]   inv_flat;
    logic                         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_txn_engine dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .sel_valid     (sel_valid),
        .sel_slot      (sel_slot),
        .refund_req    (refund_req),
        .price_flat    (price_flat),
        .restock_valid (restock_valid),
        .restock_slot  (restock_slot),
        .restock_count (restock_count),
        .change_ready  (change_ready),
        .credit        (credit),
        .vend_valid    (vend_valid),
        .vend_slot     (vend_slot),
        .change_valid  (change_valid),
        .change_amt    (change_amt),
        .err_sold_out  (err_sold_out),
        .err_funds     (err_funds),
        .err_invalid   (err_invalid),
        .inv_flat      (inv_flat),
        .busy          (busy)
    );

    function automatic int cnt_of(input int slot);
        logic [NUM_SLOTS*CNT_W-1:0] v;
        v = inv_flat;
        return int'(v[slot*CNT_W +: CNT_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_value = 8'(v);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input int s);
        sel_valid = 1'b1;
        sel_slot  = SW'(s);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic restock(input int s, input int c);
        restock_valid = 1'b1;
        restock_slot  = SW'(s);
        restock_count = CNT_W'(c);
        tick();
        restock_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({credit, change_amt, change_valid, busy, vend_valid, inv_flat} !== '0) begin
            failures++;
            $display("FAIL reset_outputs credit=%0d amt=%0d cv=%0b busy=%0b inv=%h required all zero",
                     credit, change_amt, change_valid, busy, inv_flat);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        restock(3, 2);
        restock(2, 0);
        restock(0, 5);
        checks++;
        if (cnt_of(3) !== 2) begin
            failures++;
            $display("FAIL restock_slot3 got=%0d exp=2", cnt_of(3));
        end
    endtask

    task automatic test_vend();
        coin(25);
        coin(25);
        coin(50);
        checks++;
        if (credit !== 10'd100) begin
            failures++;
            $display("FAIL vend_credit_in got=%0d exp=100", credit);
        end
        select(3);
        checks++;
        if (vend_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL vend_check_cycle vv=%0b busy=%0b exp vv=0 busy=1", vend_valid, busy);
        end
        tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_slot !== 3'd3) begin
            failures++;
            $display("FAIL vend_pulse vv=%0b slot=%0d exp vv=1 slot=3", vend_valid, vend_slot);
        end
        tick();
        checks++;
        if (vend_valid !== 1'b0 || change_valid !== 1'b1 || change_amt !== 10'd25) begin
            failures++;
            $display("FAIL vend_change vv=%0b cv=%0b amt=%0d exp vv=0 cv=1 amt=25",
                     vend_valid, change_valid, change_amt);
        end
        checks++;
        if (cnt_of(3) !== 1 || credit !== '0) begin
            failures++;
            $display("FAIL vend_count_credit cnt=%0d credit=%0d exp cnt=1 credit=0", cnt_of(3), credit);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        checks++;
        if (change_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL vend_handshake cv=%0b busy=%0b exp 0 0", change_valid, busy);
        end
    endtask

    task automatic test_sold_out();
        coin(100);
        select(2);
        tick();
        checks++;
        if (err_sold_out !== 1'b1 || err_funds !== 1'b0 || vend_valid !== 1'b0) begin
            failures++;
            $display("FAIL sold_out_pulse so=%0b funds=%0b vv=%0b exp 1 0 0", err_sold_out, err_funds, vend_valid);
        end
        checks++;
        if (credit !== 10'd100 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sold_out_state credit=%0d busy=%0b exp 100 0", credit, busy);
        end
        tick();
        checks++;
        if (err_sold_out !== 1'b0) begin
            failures++;
            $display("FAIL sold_out_one_cycle so=%0b exp 0", err_sold_out);
        end
    endtask

    task automatic test_funds();
        select(0);
        tick();
        checks++;
        if (err_funds !== 1'b1 || err_sold_out !== 1'b0 || credit !== 10'd100) begin
            failures++;
            $display("FAIL funds_pulse funds=%0b so=%0b credit=%0d exp 1 0 100", err_funds, err_sold_out, credit);
        end
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 10'd100 || credit !== '0) begin
            failures++;
            $display("FAIL funds_refund cv=%0b amt=%0d credit=%0d exp 1 100 0", change_valid, change_amt, credit);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
    endtask

    task automatic test_overflow_refund();
        for (int i = 0; i < 4; i++) coin(200);
        coin(190);
        checks++;
        if (credit !== 10'd990) begin
            failures++;
            $display("FAIL ovf_credit_990 got=%0d exp=990", credit);
        end
        coin(25);
        checks++;
        if (credit !== 10'd995) begin
            failures++;
            $display("FAIL ovf_credit_sat got=%0d exp=995", credit);
        end
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 10'd1015 || credit !== '0) begin
            failures++;
            $display("FAIL ovf_refund cv=%0b amt=%0d credit=%0d exp 1 1015 0", change_valid, change_amt, credit);
        end
    endtask

    task automatic test_change_hold();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                coin_valid = 1'b1;
                coin_value = 8'd10;
            end
            tick();
            coin_valid = 1'b0;
            checks++;
            if (change_valid !== 1'b1 || change_amt !== 10'd1015 || busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d cv=%0b amt=%0d busy=%0b exp 1 1015 1",
                         i, change_valid, change_amt, busy);
            end
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        checks++;
        if (change_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release cv=%0b busy=%0b exp 0 0", change_valid, busy);
        end
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 10'd10) begin
            failures++;
            $display("FAIL busy_coin_backlog cv=%0b amt=%0d exp 1 10", change_valid, change_amt);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
    endtask

    task automatic test_restock_collision();
        coin(75);
        select(3);
        tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_slot !== 3'd3) begin
            failures++;
            $display("FAIL coll_vend vv=%0b slot=%0d exp 1 3", vend_valid, vend_slot);
        end
        restock(3, 9);
        checks++;
        if (cnt_of(3) !== 9) begin
            failures++;
            $display("FAIL coll_restock_wins got=%0d exp=9", cnt_of(3));
        end
        checks++;
        if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== '0) begin
            failures++;
            $display("FAIL coll_exact_change cv=%0b busy=%0b credit=%0d exp 0 0 0", change_valid, busy, credit);
        end
    endtask

    task automatic test_reset_in_change();
        coin(50);
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 10'd50) begin
            failures++;
            $display("FAIL rst_pre_change cv=%0b amt=%0d exp 1 50", change_valid, change_amt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({change_valid, change_amt, credit, busy, vend_slot, vend_valid} !== '0 || inv_flat !== '0) begin
            failures++;
            $display("FAIL rst_async cv=%0b amt=%0d credit=%0d busy=%0b slot=%0d inv=%h required all zero",
                     change_valid, change_amt, credit, busy, vend_slot, inv_flat);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        coin_valid    = 1'b0;
        coin_value    = '0;
        sel_valid     = 1'b0;
        sel_slot      = '0;
        refund_req    = 1'b0;
        restock_valid = 1'b0;
        restock_slot  = '0;
        restock_count = '0;
        change_ready  = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) price_flat[i*MONEY_W +: MONEY_W] = 10'd100;
        price_flat[0*MONEY_W +: MONEY_W] = 10'd150;
        price_flat[2*MONEY_W +: MONEY_W] = 10'd50;
        price_flat[3*MONEY_W +: MONEY_W] = 10'd75;

        test_reset();
        test_vend();
        test_sold_out();
        test_funds();
        test_overflow_refund();
        test_change_hold();
        test_restock_collision();
        test_reset_in_change();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
